// File: rtl/adder_result_serializer.sv
// rtl/adder_result_serializer.sv - serializes an adder_array result set onto a lane-tagged word stream
module adder_result_serializer #(
  parameter int BIT_WIDTH = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           cmd,
  input  logic [BIT_WIDTH-1:0] din0,
  input  logic [BIT_WIDTH-1:0] din1,
  input  logic [BIT_WIDTH-1:0] din2,
  input  logic [BIT_WIDTH-1:0] din3,
  input  logic [3:0]           ovf_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic [1:0]           out_lane,
  output logic                 out_ovf,
  output logic                 out_last,
  output logic [CNT_WIDTH-1:0] ovf_count,
  input  logic                 ovf_clear
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [0:0]           state;
  logic [BIT_WIDTH-1:0] data_q [4];
  logic [BIT_WIDTH-1:0] din_arr [4];
  logic [3:0]           ovf_q;
  logic [1:0]           lane;
  logic [1:0]           end_lane;
  logic                 accept;
  logic                 out_hs;

  assign din_arr[0] = din0;
  assign din_arr[1] = din1;
  assign din_arr[2] = din2;
  assign din_arr[3] = din3;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SEND);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  // Fields read as zero outside SEND so an idle stream shows no stale words.
  assign out_data = out_valid ? data_q[lane] : '0;
  assign out_lane = out_valid ? lane : 2'd0;
  assign out_ovf  = out_valid && ovf_q[lane];
  assign out_last = out_valid && (lane == end_lane);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ovf_q    <= '0;
      lane     <= '0;
      end_lane <= '0;
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (cmd == 3'd4) begin
              for (int i = 0; i < 4; i++) data_q[i] <= din_arr[i];
              ovf_q    <= ovf_in;
              lane     <= 2'd0;
              end_lane <= 2'd3;
              state    <= SEND;
            end else if (!cmd[2]) begin
              data_q[cmd[1:0]] <= din_arr[cmd[1:0]];
              ovf_q[cmd[1:0]]  <= ovf_in[cmd[1:0]];
              lane             <= cmd[1:0];
              end_lane         <= cmd[1:0];
              state            <= SEND;
            end
          end
        end
        SEND: begin
          if (out_hs) begin
            if (out_last) state <= IDLE;
            else          lane  <= lane + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_count <= '0;
    end else if (ovf_clear) begin
      ovf_count <= '0;
    end else if (out_hs && out_ovf && (ovf_count != CNT_MAX)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_result_serializer.sv
// tb/tb_adder_result_serializer.sv - randomized self-checking bench against a word-queue model
module tb_adder_result_serializer;

  localparam int BW   = 32;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  lane;
    logic        ovf;
    logic        last;
  } word_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    cmd;
  logic [BW-1:0] din0, din1, din2, din3;
  logic [3:0]    ovf_in;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [1:0]    out_lane;
  logic          out_ovf;
  logic          out_last;
  logic [CW-1:0] ovf_count;
  logic          ovf_clear;

  int n_checks = 0;
  int n_errors = 0;
  int cnt = 0;

  adder_result_serializer #(.BIT_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .cmd(cmd), .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .ovf_in(ovf_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane(out_lane), .out_ovf(out_ovf),
    .out_last(out_last), .ovf_count(ovf_count), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: stalled 5 cycles then toggling
  task automatic run_set(input logic [2:0] c, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3, input logic [3:0] ov,
                         input int mode, input bit clr);
    word_t q[$];
    word_t w;
    logic [31:0] d [4];
    int k;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    if (c == 3'd4) begin
      for (int i = 0; i < 4; i++) begin
        w.data = d[i]; w.lane = 2'(i); w.ovf = ov[i]; w.last = (i == 3);
        q.push_back(w);
      end
    end else if (c < 3'd4) begin
      w.data = d[c]; w.lane = c[1:0]; w.ovf = ov[c]; w.last = 1'b1;
      q.push_back(w);
    end

    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; cmd = c; ovf_in = ov;
    din0 = d0; din1 = d1; din2 = d2; din3 = d3;
    @(posedge clk); #1;
    in_valid = 1'b0;

    k = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      if (k > 60) begin
        check("word_timeout", q.size(), 0);
        break;
      end
      w = q[0];
      check("out_valid", out_valid, 1);
      check("in_ready_busy", in_ready, 0);
      check("out_data", out_data, w.data);
      check("out_lane", out_lane, w.lane);
      check("out_ovf", out_ovf, w.ovf);
      check("out_last", out_last, w.last);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (k < 5) ? 1'b0 : 1'(k % 2);
      endcase
      ovf_clear = clr && out_ready && w.last;
      if (out_ready) begin
        if (ovf_clear)                 cnt = 0;
        else if (w.ovf && cnt < CMAX)  cnt = cnt + 1;
        void'(q.pop_front());
      end
      k++;
      @(posedge clk); #1;
      out_ready = 1'b0;
      ovf_clear = 1'b0;
      // Busy-time input noise must be ignored.
      in_valid = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd = 3'($urandom); din0 = $urandom; din1 = $urandom;
      din2 = $urandom; din3 = $urandom; ovf_in = 4'($urandom);
    end
    in_valid = 1'b0;

    @(negedge clk);
    check("end_out_valid", out_valid, 0);
    check("end_in_ready", in_ready, 1);
    check("ovf_count", ovf_count, cnt);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; cmd = '0; ovf_in = '0;
    din0 = '0; din1 = '0; din2 = '0; din3 = '0;
    out_ready = 1'b0; ovf_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_lane", out_lane, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_out_last", out_last, 0);
    check("rst_ovf_count", ovf_count, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);

    run_set(3'd2, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 4'b0100, 0, 1'b0);
    run_set(3'd4, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'b1010, 0, 1'b0);
    run_set(3'd1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0, 32'h0, 4'b0010, 0, 1'b1);
    run_set(3'd4, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 4'b1010, 2, 1'b0);
    run_set(3'd6, 32'h5, 32'h6, 32'h7, 32'h8, 4'b1111, 0, 1'b0);
    for (int i = 0; i < 5; i++)
      run_set(3'd3, $urandom, $urandom, $urandom, $urandom, 4'b1000, 0, 1'b0);
    run_set(3'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 4'b0001, 0, 1'b1);

    for (int i = 0; i < 30; i++)
      run_set(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom,
              4'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0));

    // Reset in the middle of a four-lane set.
    @(negedge clk);
    in_valid = 1'b1; cmd = 3'd4; ovf_in = 4'b0011;
    din0 = 32'h10; din1 = 32'h11; din2 = 32'h12; din3 = 32'h13;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("mid_lane", out_lane, 2);
    check("mid_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    cnt = 0;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_ovf_count", ovf_count, cnt);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_abort_valid", out_valid, 0);
      check("post_abort_in_ready", in_ready, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
